// File: rtl/ov7670_capture.sv
// OV7670 byte-stream capture: pairs camera bytes into RGB565 pixels and
// streams them as addressed framebuffer writes, with optional 2:1 decimation.
module ov7670_capture #(
    parameter int p_width      = 640,
    parameter int p_height     = 480,
    parameter int p_scaler     = 1,
    parameter int p_addr_width = 19
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_enable,
    input  logic                    i_vsync,
    input  logic                    i_href,
    input  logic [7:0]              i_data,
    output logic                    o_wr_valid,
    output logic [p_addr_width-1:0] o_wr_addr,
    output logic [15:0]             o_wr_data,
    input  logic                    i_wr_ready,
    output logic                    o_frame_start,
    output logic                    o_frame_done,
    output logic                    o_line_err,
    output logic                    o_overflow
);

    localparam int XW = $clog2(p_width + 1);
    localparam int YW = $clog2(p_height + 1);
    localparam logic [XW-1:0] XMAX = XW'(p_width);
    localparam logic [YW-1:0] YMAX = YW'(p_height);

    typedef enum logic [1:0] {
        S_WAIT_VSYNC = 2'd0,
        S_WAIT_FRAME = 2'd1,
        S_CAPTURE    = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    vsync_q, vsync_d;
    logic                    href_q, href_d;
    logic [7:0]              data_q, data_d;
    logic                    vsync_prev_q, vsync_prev_d;
    logic                    href_prev_q, href_prev_d;
    logic [XW-1:0]           x_q, x_d;
    logic [YW-1:0]           y_q, y_d;
    logic                    phase_q, phase_d;
    logic [7:0]              hi_q, hi_d;
    logic                    pend_q, pend_d;
    logic [15:0]             pend_data_q, pend_data_d;
    logic [p_addr_width-1:0] addr_q, addr_d;
    logic                    wr_valid_q, wr_valid_d;
    logic [p_addr_width-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]             wr_data_q, wr_data_d;
    logic                    frame_start_q, frame_start_d;
    logic                    frame_done_q, frame_done_d;
    logic                    line_err_q, line_err_d;
    logic                    overflow_q, overflow_d;

    logic vs_rise;
    logic vs_fall;
    logic hr_fall;
    logic keep_x;
    logic keep_y;

    assign vs_rise = vsync_q & ~vsync_prev_q;
    assign vs_fall = ~vsync_q & vsync_prev_q;
    assign hr_fall = href_prev_q & ~href_q;
    assign keep_x  = (p_scaler == 1) || !x_q[0];
    assign keep_y  = (p_scaler == 1) || !y_q[0];

    always_comb begin
        vsync_d       = i_vsync;
        href_d        = i_href;
        data_d        = i_data;
        vsync_prev_d  = vsync_q;
        href_prev_d   = href_q;
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        phase_d       = phase_q;
        hi_d          = hi_q;
        pend_d        = 1'b0;
        pend_data_d   = pend_data_q;
        addr_d        = addr_q;
        wr_valid_d    = pend_q;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        line_err_d    = line_err_q;
        overflow_d    = overflow_q;

        // Output stage: the address advances even if the write is dropped
        if (pend_q) begin
            wr_addr_d = addr_q;
            wr_data_d = pend_data_q;
            addr_d    = addr_q + p_addr_width'(1);
        end

        if (wr_valid_q && !i_wr_ready) begin
            overflow_d = 1'b1;
        end

        unique case (state_q)
            S_WAIT_VSYNC: begin
                if (vsync_q) begin
                    state_d = S_WAIT_FRAME;
                end
            end
            S_WAIT_FRAME: begin
                if (vs_fall && i_enable) begin
                    state_d       = S_CAPTURE;
                    frame_start_d = 1'b1;
                    x_d           = '0;
                    y_d           = '0;
                    phase_d       = 1'b0;
                    addr_d        = '0;
                    wr_addr_d     = '0;
                    line_err_d    = 1'b0;
                    overflow_d    = 1'b0;
                end
            end
            S_CAPTURE: begin
                // A vsync edge closes any open line without emitting a pixel
                if (vs_rise) begin
                    state_d      = S_WAIT_FRAME;
                    frame_done_d = 1'b1;
                    x_d          = '0;
                    phase_d      = 1'b0;
                    if (y_q != YMAX) begin
                        line_err_d = 1'b1;
                    end
                end else if (href_q) begin
                    if (y_q >= YMAX) begin
                        line_err_d = 1'b1;
                    end else if (!phase_q) begin
                        hi_d    = data_q;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (x_q < XMAX) begin
                            x_d = x_q + XW'(1);
                            if (keep_x && keep_y) begin
                                pend_d      = 1'b1;
                                pend_data_d = {hi_q, data_q};
                            end
                        end else begin
                            line_err_d = 1'b1;
                        end
                    end
                end else if (hr_fall) begin
                    x_d     = '0;
                    phase_d = 1'b0;
                    if (y_q < YMAX) begin
                        y_d = y_q + YW'(1);
                        if (x_q != XMAX || phase_q) begin
                            line_err_d = 1'b1;
                        end
                    end else begin
                        line_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_WAIT_VSYNC;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= S_WAIT_VSYNC;
            vsync_q       <= 1'b0;
            href_q        <= 1'b0;
            data_q        <= '0;
            vsync_prev_q  <= 1'b0;
            href_prev_q   <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            phase_q       <= 1'b0;
            hi_q          <= '0;
            pend_q        <= 1'b0;
            pend_data_q   <= '0;
            addr_q        <= '0;
            wr_valid_q    <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            line_err_q    <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            vsync_q       <= vsync_d;
            href_q        <= href_d;
            data_q        <= data_d;
            vsync_prev_q  <= vsync_prev_d;
            href_prev_q   <= href_prev_d;
            x_q           <= x_d;
            y_q           <= y_d;
            phase_q       <= phase_d;
            hi_q          <= hi_d;
            pend_q        <= pend_d;
            pend_data_q   <= pend_data_d;
            addr_q        <= addr_d;
            wr_valid_q    <= wr_valid_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            line_err_q    <= line_err_d;
            overflow_q    <= overflow_d;
        end
    end

    assign o_wr_valid    = wr_valid_q;
    assign o_wr_addr     = wr_addr_q;
    assign o_wr_data     = wr_data_q;
    assign o_frame_start = frame_start_q;
    assign o_frame_done  = frame_done_q;
    assign o_line_err    = line_err_q;
    assign o_overflow    = overflow_q;

endmodule
